// File: rtl/module_display_scan_pkg.sv
// Shared types and segment constants for the seven-segment scan driver.
package pkg_display;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/module_display_scan_hex_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module module_hex_7seg
  import pkg_display::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Nibble to segment pattern lookup
  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/module_display_scan.sv
// Multiplexed 7-seg scan driver with blanking dead time and frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
module module_display_scan
  import pkg_display::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int BLANK_TICKS = 1
)(
  input  logic                  clk_10Mhz_i,
  input  logic                  reset_i,
  input  logic                  tick_i,
  input  logic                  load_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  output logic [N_DIGITS-1:0]   anodo_o,
  output logic [6:0]            catodo_o,
  output logic                  dp_o,
  output logic                  pending_o,
  output logic                  frame_o
);

  localparam int DW = 4 * N_DIGITS;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLANK_TICKS - 1);

  scan_state_t         r_state;
  logic [IW-1:0]       r_idx;
  logic [BW-1:0]       r_bcnt;
  logic [DW-1:0]       r_shadow_data;
  logic [N_DIGITS-1:0] r_shadow_dp;
  logic [DW-1:0]       r_disp_data;
  logic [N_DIGITS-1:0] r_disp_dp;
  logic                r_pending;
  logic [N_DIGITS-1:0] r_anodo;
  logic [6:0]          r_catodo;
  logic                r_dp;
  logic                r_frame;

  scan_state_t         w_state_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic [BW-1:0]       w_bcnt_nxt;
  logic                w_commit;
  logic [DW-1:0]       w_shadow_data_nxt;
  logic [N_DIGITS-1:0] w_shadow_dp_nxt;
  logic [DW-1:0]       w_disp_data_nxt;
  logic [N_DIGITS-1:0] w_disp_dp_nxt;
  logic                w_pending_nxt;
  logic [3:0]          w_nibble;
  logic                w_sel_dp;
  logic [6:0]          w_seg;
  logic                w_lead_blank;
  logic                w_show;
  logic [N_DIGITS-1:0] w_anodo_nxt;
  logic [6:0]          w_catodo_nxt;
  logic                w_dp_nxt;

  // Scan FSM next state; only tick cycles advance
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_bcnt_nxt  = r_bcnt;
    w_commit    = 1'b0;
    if (tick_i) begin
      case (r_state)
        BLANK: begin
          if (r_bcnt == BCNT_LAST) begin
            w_state_nxt = SHOW;
            w_bcnt_nxt  = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt = '0;
              w_commit  = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IW'(1);
            end
          end else begin
            w_bcnt_nxt = r_bcnt + BW'(1);
          end
        end
        SHOW:    w_state_nxt = BLANK;
        default: w_state_nxt = BLANK;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Shadow/display buffers; a load coinciding with a commit bypasses the shadow
  always_comb begin
    w_shadow_data_nxt = r_shadow_data;
    w_shadow_dp_nxt   = r_shadow_dp;
    w_disp_data_nxt   = r_disp_data;
    w_disp_dp_nxt     = r_disp_dp;
    w_pending_nxt     = r_pending;
    if (load_i) begin
      w_shadow_data_nxt = data_i;
      w_shadow_dp_nxt   = dp_i;
    end else begin
      w_shadow_data_nxt = r_shadow_data;
    end
    if (w_commit) begin
      w_pending_nxt = 1'b0;
      if (load_i) begin
        w_disp_data_nxt = data_i;
        w_disp_dp_nxt   = dp_i;
      end else if (r_pending) begin
        w_disp_data_nxt = r_shadow_data;
        w_disp_dp_nxt   = r_shadow_dp;
      end else begin
        w_disp_data_nxt = r_disp_data;
      end
    end else if (load_i) begin
      w_pending_nxt = 1'b1;
    end else begin
      w_pending_nxt = r_pending;
    end
  end

  // Select the nibble and dp bit of the digit about to be shown
  always_comb begin
    w_nibble = 4'h0;
    w_sel_dp = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (w_idx_nxt == IW'(k)) begin
        w_nibble = w_disp_data_nxt[4*k +: 4];
        w_sel_dp = w_disp_dp_nxt[k];
      end else begin
        w_sel_dp = w_sel_dp;
      end
    end
  end

`ifdef DISPLAY_LZB_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 never is
  always_comb begin
    w_lead_blank = 1'b0;
    for (int k = 1; k < N_DIGITS; k++) begin
      if (w_idx_nxt == IW'(k)) begin
        w_lead_blank = ((w_disp_data_nxt >> (4 * k)) == '0);
      end else begin
        w_lead_blank = w_lead_blank;
      end
    end
  end
`else
  assign w_lead_blank = 1'b0;
`endif

  module_hex_7seg u_hex_7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Pin values for the upcoming state, so outputs stay registered
  always_comb begin
    w_show      = (w_state_nxt == SHOW) && !w_lead_blank;
    w_anodo_nxt = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_anodo_nxt[k] = !(w_show && (w_idx_nxt == IW'(k)));
    end
    if (w_show) begin
      w_catodo_nxt = w_seg;
      w_dp_nxt     = ~w_sel_dp;
    end else begin
      w_catodo_nxt = SEG_OFF;
      w_dp_nxt     = 1'b1;
    end
  end

  // State, buffer and output registers
  always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= BLANK;
      r_idx         <= IDX_LAST;
      r_bcnt        <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_disp_data   <= '0;
      r_disp_dp     <= '0;
      r_pending     <= 1'b0;
      r_anodo       <= '1;
      r_catodo      <= SEG_OFF;
      r_dp          <= 1'b1;
      r_frame       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_bcnt        <= w_bcnt_nxt;
      r_shadow_data <= w_shadow_data_nxt;
      r_shadow_dp   <= w_shadow_dp_nxt;
      r_disp_data   <= w_disp_data_nxt;
      r_disp_dp     <= w_disp_dp_nxt;
      r_pending     <= w_pending_nxt;
      r_anodo       <= w_anodo_nxt;
      r_catodo      <= w_catodo_nxt;
      r_dp          <= w_dp_nxt;
      r_frame       <= w_commit;
    end
  end

  assign anodo_o   = r_anodo;
  assign catodo_o  = r_catodo;
  assign dp_o      = r_dp;
  assign pending_o = r_pending;
  assign frame_o   = r_frame;

endmodule

// File: tb/tb_module_display_scan.sv
// Scoreboard bench for module_display_scan: directed scan/load/commit/reset vectors,
// plus a second instance with three blanking ticks.
module tb_module_display_scan;

`ifdef DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rst2, tick, load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  an, an2;
  logic [6:0]  cat, cat2;
  logic        dpo, dpo2, pend, pend2, frm, frm2;

  always #50 clk = ~clk;

  module_display_scan #(.N_DIGITS(4), .BLANK_TICKS(1)) dut (
    .clk_10Mhz_i (clk), .reset_i (rst), .tick_i (tick), .load_i (load),
    .data_i (data), .dp_i (dp), .anodo_o (an), .catodo_o (cat), .dp_o (dpo),
    .pending_o (pend), .frame_o (frm)
  );

  module_display_scan #(.N_DIGITS(4), .BLANK_TICKS(3)) dut3 (
    .clk_10Mhz_i (clk), .reset_i (rst2), .tick_i (tick), .load_i (load),
    .data_i (data), .dp_i (dp), .anodo_o (an2), .catodo_o (cat2), .dp_o (dpo2),
    .pending_o (pend2), .frame_o (frm2)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] cat;
    logic       dp;
    logic       frame;
    logic       pend;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  int   ev_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: after every tick/load cycle compare outputs with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (mon_en && (tick || load)) begin
        @(negedge clk);
        ev_n++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_underflow: event %0d has no expectation", ev_n);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("scan_ev%0d {an,cat,dp,frame,pend}", ev_n),
              32'({an, cat, dpo, frm, pend}), 32'(e));
        end
      end
    end
  end

  task automatic step(input bit t, input bit l, input logic [15:0] d, input logic [3:0] p,
                      input logic [3:0] ean, input logic [6:0] ecat, input logic edp,
                      input logic efr, input logic epd);
    tick = t;
    load = l;
    if (l) begin
      data = d;
      dp   = p;
    end
    sb_q.push_back({ean, ecat, edp, efr, epd});
    @(negedge clk);
    tick = 1'b0;
    load = 1'b0;
  endtask

  task automatic tk(input logic [3:0] ean, input logic [6:0] ecat, input logic edp,
                    input logic efr, input logic epd);
    step(1'b1, 1'b0, 16'h0000, 4'h0, ean, ecat, edp, efr, epd);
  endtask

  task automatic bl(input logic epd);
    tk(4'hF, 7'h7F, 1'b1, 1'b0, epd);
  endtask

  initial begin
    logic [3:0] ea;
    rst = 1'b1; rst2 = 1'b1; tick = 1'b0; load = 1'b0; data = 16'h0; dp = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_anodo", 32'(an), 32'h0000_000F);
    chk("reset_catodo", 32'(cat), 32'h0000_007F);
    chk("reset_dp", 32'(dpo), 32'h1);
    chk("reset_pending", 32'(pend), 32'h0);
    chk("reset_frame", 32'(frm), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Digit order with 1234
    step(1'b0, 1'b1, 16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
    tk(4'hE, 7'h19, 1'b1, 1'b1, 1'b0);
    bl(1'b0);
    tk(4'hD, 7'h30, 1'b1, 1'b0, 1'b0);
    bl(1'b0);
    tk(4'hB, 7'h24, 1'b1, 1'b0, 1'b0);

    // Double buffering: ABCD staged mid-frame, old value kept until digit 0
    step(1'b0, 1'b1, 16'hABCD, 4'b0010, 4'hB, 7'h24, 1'b1, 1'b0, 1'b1);
    bl(1'b1);
    tk(4'h7, 7'h79, 1'b1, 1'b0, 1'b1);
    bl(1'b1);
    tk(4'hE, 7'h21, 1'b1, 1'b1, 1'b0);
    bl(1'b0);
    tk(4'hD, 7'h46, 1'b0, 1'b0, 1'b0);
    bl(1'b0);
    tk(4'hB, 7'h03, 1'b1, 1'b0, 1'b0);
    bl(1'b0);
    tk(4'h7, 7'h08, 1'b1, 1'b0, 1'b0);
    bl(1'b0);

    // Load coinciding with the commit tick
    step(1'b1, 1'b1, 16'h0F00, 4'h0, 4'hE, 7'h40, 1'b1, 1'b1, 1'b0);
    bl(1'b0);
    tk(4'hD, 7'h40, 1'b1, 1'b0, 1'b0);
    bl(1'b0);
    tk(4'hB, 7'h0E, 1'b1, 1'b0, 1'b0);
    bl(1'b0);
    tk(LZB ? 4'hF : 4'h7, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0, 1'b0);
    bl(1'b0);

    // Leading zeros: 0005 with dp on digit 3
    step(1'b0, 1'b1, 16'h0005, 4'b1000, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
    tk(4'hE, 7'h12, 1'b1, 1'b1, 1'b0);
    bl(1'b0);
    tk(LZB ? 4'hF : 4'hD, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0, 1'b0);
    bl(1'b0);
    tk(LZB ? 4'hF : 4'hB, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0, 1'b0);
    bl(1'b0);
    tk(LZB ? 4'hF : 4'h7, LZB ? 7'h7F : 7'h40, LZB ? 1'b1 : 1'b0, 1'b0, 1'b0);
    bl(1'b0);

    // Async reset during digit-2 slot with a staged value
    tk(4'hE, 7'h12, 1'b1, 1'b1, 1'b0);
    bl(1'b0);
    step(1'b0, 1'b1, 16'h9999, 4'hF, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
    tk(LZB ? 4'hF : 4'hD, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0, 1'b1);
    bl(1'b1);
    tk(LZB ? 4'hF : 4'hB, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0, 1'b1);
    #20;
    rst = 1'b1;
    #5;
    chk("async_rst_anodo", 32'(an), 32'h0000_000F);
    chk("async_rst_catodo", 32'(cat), 32'h0000_007F);
    chk("async_rst_dp", 32'(dpo), 32'h1);
    chk("async_rst_pending", 32'(pend), 32'h0);
    chk("async_rst_frame", 32'(frm), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tk(4'hE, 7'h40, 1'b1, 1'b1, 1'b0);
    bl(1'b0);
    tk(LZB ? 4'hF : 4'hD, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    // Three-tick dead time on the second instance
    rst2 = 1'b0;
    @(negedge clk);
    load = 1'b1; data = 16'h1111; dp = 4'h0;
    @(negedge clk);
    load = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      ea = 4'hF;
      if ((t % 4) == 3) begin
        ea[t / 4] = 1'b0;
        chk($sformatf("dead3_show_t%0d_anodo", t), 32'(an2), 32'(ea));
        chk($sformatf("dead3_show_t%0d_catodo", t), 32'(cat2), 32'h0000_0079);
      end else begin
        chk($sformatf("dead3_blank_t%0d_anodo", t), 32'(an2), 32'h0000_000F);
        chk($sformatf("dead3_blank_t%0d_catodo", t), 32'(cat2), 32'h0000_007F);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
